// File: rtl/ahb_slave_mem_responder.sv
// AHB-Lite subordinate backed by a byte-addressed local memory, with wait-state and ERROR responses.
// Optional: define AHB_SLV_WAIT_STATE_EN to add the wait_states port and programmable wait states.
module ahb_slave_mem_responder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] MIN_ADDR      = 'h0,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR      = 'hFFF,
  parameter int                    WAIT_WIDTH    = 4
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
`ifdef AHB_SLV_WAIT_STATE_EN
  input  logic [WAIT_WIDTH-1:0]   wait_states,
`endif
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic [2:0]              dbg_state
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_BITS = MEM_ADDR_BITS - OFF_BITS;
  localparam int WORDS    = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                   state, next_state;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic                     write_q;
  logic [2:0]               size_q;
  logic [WAIT_WIDTH-1:0]    cnt_q, cnt_d, wait_val;
  logic                     accept, load, addr_err, wr_commit;
  logic [ADDR_WIDTH:0]      below_diff, above_diff;
  logic [ADDR_WIDTH-1:0]    size_mask;
  logic [BYTES-1:0]         lane_en;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     unused_inputs;

`ifdef AHB_SLV_WAIT_STATE_EN
  assign wait_val = wait_states;
`else
  assign wait_val = '0;
`endif

  assign unused_inputs = ^{hburst, hprot};

  // Handshake: an address phase is offered when hselx & htrans[1] and taken when hready=1;
  // its data phase completes on the first rising edge at which hreadyout=1.
  assign accept    = hselx & hready & htrans[1];
  assign wr_commit = (state == ST_DATA) & write_q;
  assign dbg_state = state;

  // Range checks use borrow bits so a zero MIN_ADDR needs no special casing.
  always_comb begin
    below_diff = {1'b0, haddr} - {1'b0, MIN_ADDR};
    above_diff = {1'b0, MAX_ADDR} - {1'b0, haddr};
    size_mask  = ADDR_WIDTH'((32'd1 << hsize) - 32'd1);
    addr_err   = below_diff[ADDR_WIDTH] | above_diff[ADDR_WIDTH]
               | ((32'd8 << hsize) > 32'(DATA_WIDTH))
               | ((haddr & size_mask) != '0);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state <= next_state;
      cnt_q <= cnt_d;
      if (load) begin
        addr_q  <= haddr[MEM_ADDR_BITS-1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    load       = 1'b0;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        hresp = (state == ST_ERR2);
        if (accept) begin
          load = 1'b1;
          if (addr_err) begin
            next_state = ST_ERR1;
          end else if (wait_val != '0) begin
            next_state = ST_WAIT;
            cnt_d      = wait_val;
          end else begin
            next_state = ST_DATA;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q <= WAIT_WIDTH'(1)) next_state = ST_DATA;
        else cnt_d = cnt_q - WAIT_WIDTH'(1);
      end
      ST_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = 1'b1;
        next_state = ST_ERR2;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A lane is writable only if it lies inside the hsize window at the registered offset.
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < BYTES; i++)
      lane_en[i] = (i >= int'(addr_q[OFF_BITS-1:0])) &&
                   (i < int'(addr_q[OFF_BITS-1:0]) + (1 << size_q));
  end

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    always_ff @(posedge hclk) begin
      if (wr_commit && hwstrb[g] && lane_en[g])
        lane_mem[addr_q[MEM_ADDR_BITS-1:OFF_BITS]] <= hwdata[8*g +: 8];
    end
    assign rd_word[8*g +: 8] = lane_mem[addr_q[MEM_ADDR_BITS-1:OFF_BITS]];
  end

  assign hrdata = (state == ST_DATA) ? rd_word : '0;

endmodule
